control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Instruction-sequencing FSM for the 8051 core; drives the datapath's control strobes and consumes the `Opcode` the datapath returns.
- Per instruction it issues fetch, second-byte fetch, RAM access, ALU execute or jump strobes, then returns to fetch.
- Sits beside the datapath in the core top level.
- Supported subset: MOV, ADD, SUBB, ANL, ORL, INC A, DEC A, JZ, JNZ, JNC, AJMP, NOP.

Parameters:
RAM_WAIT, 0, extra cycles the RAM_access code is held in MEM state (0..7)
ILLEGAL_AS_NOP, 1, 1 = undecodable opcode retires as NOP; 0 = FSM parks in HALT

Ports:
clock  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
Opcode  in  8  current IR from datapath, valid from DECODE onward
hold  in  1  stall request; freezes FSM
IRload  out  1  fetch strobe
PCload  out  1  PC increment strobe
NotRload  out  1  1 during second-byte fetch (operand into addr1)
RAM_access  out  4  RAM access code (define_opcodes.v)
Aload  out  1  ALU execute / accumulator writeback strobe
ALU_Opcode  out  4  ALU operation code (define_opcodes.v)
JMPload  out  1  conditional/absolute jump strobe
instr_done  out  1  one-cycle pulse on last cycle of each instruction
illegal  out  1  one-cycle pulse in DECODE on unsupported opcode

Behaviour:
- Reset (reset=0, async): state=FETCH1; all strobes 0; RAM_access=RAM_IDLE; ALU_Opcode=ALU_NOP; wait counter=0. Outputs stay there until the first rising edge after release.
- All outputs are registered Moore decodes of state. Only the listed strobes are 1 in each state. RAM_access is RAM_IDLE outside MEM.
- FETCH1: IRload=1, PCload=1, NotRload=0 -> DECODE.
- DECODE: latch class from Opcode.
  - 2-byte class (#imm, direct, JZ/JNZ/JNC, AJMP) -> FETCH2.
  - Rn/@Ri MOV/ALU -> MEM.
  - INC A/DEC A -> EXEC.
  - NOP -> FETCH1 with instr_done.
  - Illegal -> FETCH1 with illegal=1 and instr_done (ILLEGAL_AS_NOP=1), else HALT.
- FETCH2: IRload=PCload=NotRload=1 -> JUMP for jump class, else MEM.
- MEM: RAM_access held for RAM_WAIT+1 cycles (counter). Codes:
  - #imm -> RD_RAM_IM
  - direct -> RD_RAM_DIRECT
  - Rn read (low 3 bits 1xxx form) -> RD_RAM_REG
  - @Ri read -> RD_RAM_REG_IND
  - MOV Rn,A -> WR_RAM_REG
  - MOV @Ri,A -> WR_RAM_REG_IND
  - After the hold: write classes -> FETCH1 with instr_done; read classes -> EXEC.
- EXEC: Aload=1, ALU_Opcode per family (ALU_ADD, ALU_SUBB, ALU_ANL, ALU_ORL, ALU_INC, ALU_DEC, ALU_NOP for MOV A,src) -> FETCH1, instr_done=1.
- JUMP: JMPload=1 for exactly one cycle; condition evaluation is in the datapath -> FETCH1, instr_done=1.
- HALT: all strobes 0; exits only via reset.
- Opcode map (8051 encoding):
  - MOV A: E5/E6-E7/E8-EF/74
  - MOV to reg: F6-F7/F8-FF
  - ADD 24-2F, SUBB 94-9F, ORL 44-4F, ANL 54-5F (each at x4/x5/x6-x7/x8-xF)
  - INC A 04, DEC A 14
  - JZ 60, JNZ 70, JNC 50
  - AJMP xxx00001
  - NOP 00
- hold=1: state, counter and class frozen; all strobes and instr_done forced 0; RAM_access forced RAM_IDLE. Resume continues at the same state with the full remaining MEM count.
- hold and reset together: reset wins.
- Reset mid-instruction: abandons it, no partial strobe after reset asserts.
- Latencies (RAM_WAIT=0):
  - NOP 2 cycles
  - INC/DEC 3
  - Rn/@Ri ALU and MOV Rn,A 4/3
  - #imm/direct 5
  - jump 4

Decomposition:
- Add RAM_IDLE, the ALU_NOP code, the state encodings and opcode class constants to define_opcodes.v, shared with the datapath.
- One sub-module is natural: opcode_classifier (combinational Opcode -> class, RAM code, ALU code, two_byte, illegal). The FSM and counter stay in control_unit.

Test Plan:
- Reset low for 3 cycles mid-MEM, release -> all strobes 0 while low; first cycle after release IRload=PCload=1, NotRload=0.
- Opcode=0x28 (ADD A,R0), RAM_WAIT=0 -> FETCH1, DECODE, MEM(RAM_access=RD_RAM_REG), EXEC(Aload=1, ALU_Opcode=ALU_ADD); instr_done on cycle 4.
- Opcode=0x74 (MOV A,#imm) -> FETCH2 with NotRload=1, then RD_RAM_IM, then Aload with ALU_NOP; 5 cycles. Repeat with RAM_WAIT=2 -> RD_RAM_IM held 3 cycles, 7 total.
- Opcode=0x60 (JZ), then 0x21 (AJMP) -> FETCH2 then exactly one JMPload pulse, no Aload, RAM_access stays RAM_IDLE; 4 cycles each.
- Opcode=0xF9 (MOV R1,A) with hold=1 asserted for 2 cycles during MEM -> WR_RAM_REG dropped to RAM_IDLE while held, resumes for full count, instr_done after.
- Opcode=0xA5 (unsupported): ILLEGAL_AS_NOP=1 -> illegal pulse, next FETCH1. ILLEGAL_AS_NOP=0 -> HALT, no strobes for 20 cycles until reset.

Source files
------------

// File: rtl/control_unit_pkg.sv
// -----------------------------------------------------------------------------
// control_unit_pkg
// Shared definitions between the 8051 control unit and the datapath:
//   - RAM access codes driven on RAM_access
//   - ALU operation codes driven on ALU_Opcode
//   - FSM state encodings (plain localparams so legacy code can compare them)
//   - opcode class enum and the decoded-instruction / control-strobe structs
//   - helper functions used by the opcode classifier
// -----------------------------------------------------------------------------
package control_unit_pkg;

   // RAM access codes
   localparam logic [3:0] RAM_IDLE       = 4'd0;
   localparam logic [3:0] RD_RAM_IM      = 4'd1;
   localparam logic [3:0] RD_RAM_DIRECT  = 4'd2;
   localparam logic [3:0] RD_RAM_REG     = 4'd3;
   localparam logic [3:0] RD_RAM_REG_IND = 4'd4;
   localparam logic [3:0] WR_RAM_REG     = 4'd5;
   localparam logic [3:0] WR_RAM_REG_IND = 4'd6;

   // ALU operation codes (ALU_NOP passes the operand through, used by MOV A,src)
   localparam logic [3:0] ALU_NOP  = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUBB = 4'd2;
   localparam logic [3:0] ALU_ANL  = 4'd3;
   localparam logic [3:0] ALU_ORL  = 4'd4;
   localparam logic [3:0] ALU_INC  = 4'd5;
   localparam logic [3:0] ALU_DEC  = 4'd6;

   // FSM state encodings
   localparam logic [2:0] S_FETCH1 = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_FETCH2 = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_EXEC   = 3'd4;
   localparam logic [2:0] S_JUMP   = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   // Opcode classes: decide where DECODE goes next
   typedef enum logic [2:0] {
      CLS_NOP,       // retire straight from DECODE
      CLS_ACC,       // INC A / DEC A: accumulator only, straight to EXEC
      CLS_RAM,       // Rn / @Ri operand, no second byte
      CLS_TWO_BYTE,  // #imm, direct, or jump: needs FETCH2
      CLS_ILLEGAL
   } op_class_e;

   // Per-instruction information kept from DECODE until the instruction retires
   typedef struct packed {
      logic [3:0] ram_code;
      logic [3:0] alu_code;
      logic       is_jump;
      logic       is_write;
   } exec_info_t;

   typedef struct packed {
      op_class_e  op_class;
      logic       two_byte;
      logic       illegal;
      exec_info_t info;
   } decode_t;

   // Registered control strobes presented to the datapath
   typedef struct packed {
      logic       ir_load;
      logic       pc_load;
      logic       notr_load;
      logic [3:0] ram_access;
      logic       a_load;
      logic [3:0] alu_opcode;
      logic       jmp_load;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

   localparam exec_info_t INFO_NONE = '{
      ram_code: RAM_IDLE, alu_code: ALU_NOP, is_jump: 1'b0, is_write: 1'b0
   };

   localparam ctrl_t CTRL_IDLE = '{
      ir_load: 1'b0, pc_load: 1'b0, notr_load: 1'b0, ram_access: RAM_IDLE,
      a_load: 1'b0, alu_opcode: ALU_NOP, jmp_load: 1'b0, instr_done: 1'b0,
      illegal: 1'b0
   };

   // Operand source from the low opcode nibble (x4 #imm, x5 direct,
   // x6-x7 @Ri, x8-xF Rn). Returns RAM_IDLE for nibbles 0-3.
   function automatic logic [3:0] src_ram_code(input logic [3:0] lo);
      logic [3:0] code;
      code = RAM_IDLE;
      if (lo[3]) begin
         code = RD_RAM_REG;
      end else begin
         case (lo[2:0])
            3'd4:       code = RD_RAM_IM;
            3'd5:       code = RD_RAM_DIRECT;
            3'd6, 3'd7: code = RD_RAM_REG_IND;
            default:    code = RAM_IDLE;
         endcase
      end
      return code;
   endfunction

   // Arithmetic/logic family from the high nibble: {valid, alu_code}
   function automatic logic [4:0] alu_family(input logic [3:0] hi);
      logic [4:0] fam;
      case (hi)
         4'h2:    fam = {1'b1, ALU_ADD};
         4'h9:    fam = {1'b1, ALU_SUBB};
         4'h4:    fam = {1'b1, ALU_ORL};
         4'h5:    fam = {1'b1, ALU_ANL};
         default: fam = {1'b0, ALU_NOP};
      endcase
      return fam;
   endfunction

endpackage

// File: rtl/control_unit_opcode_classifier.sv
// -----------------------------------------------------------------------------
// control_unit_opcode_classifier
// Purely combinational decode of the 8051 opcode into the class that steers
// the control FSM plus the RAM access code and ALU code for that instruction.
//
// Ports:
//   opcode_i  in  8         current instruction register
//   decode_o  out decode_t  class, two_byte, illegal, RAM code, ALU code,
//                           jump / write flags
// -----------------------------------------------------------------------------
module control_unit_opcode_classifier
   import control_unit_pkg::*;
(
   input  logic [7:0] opcode_i,
   output decode_t    decode_o
);

   logic [4:0] fam_w;
   logic [3:0] src_w;
   logic       src_two_byte_w;
   logic       mov_a_w;

   op_class_e  cls;
   logic [3:0] ram;
   logic [3:0] alu;
   logic       jmp;
   logic       wr;

   assign fam_w          = alu_family(opcode_i[7:4]);
   assign src_w          = src_ram_code(opcode_i[3:0]);
   // #imm (x4) and direct (x5) carry their operand in a second byte
   assign src_two_byte_w = (opcode_i[3:1] == 3'b010);
   // MOV A,src: 74 (#imm) and E5-EF; E4 is CLR A and stays unsupported
   assign mov_a_w        = (opcode_i == 8'h74) ||
                           ((opcode_i[7:4] == 4'hE) && (opcode_i[3:0] >= 4'h5));

   always_comb begin
      // NOTE: every variable gets a default first so no path through the
      // decode can leave one unassigned and infer a latch.
      cls = CLS_ILLEGAL;
      ram = RAM_IDLE;
      alu = ALU_NOP;
      jmp = 1'b0;
      wr  = 1'b0;

      if (opcode_i == 8'h00) begin
         cls = CLS_NOP;
      end else if (opcode_i == 8'h04) begin
         cls = CLS_ACC;
         alu = ALU_INC;
      end else if (opcode_i == 8'h14) begin
         cls = CLS_ACC;
         alu = ALU_DEC;
      end else if ((opcode_i inside {8'h50, 8'h60, 8'h70}) ||
                   (opcode_i[4:0] == 5'b00001)) begin
         // JNC/JZ/JNZ and AJMP: target byte follows, condition lives in the datapath
         cls = CLS_TWO_BYTE;
         jmp = 1'b1;
      end else if ((fam_w[4] && (src_w != RAM_IDLE)) || mov_a_w) begin
         cls = src_two_byte_w ? CLS_TWO_BYTE : CLS_RAM;
         ram = src_w;
         alu = fam_w[3:0];
      end else if ((opcode_i[7:4] == 4'hF) && (opcode_i[3:0] >= 4'h6)) begin
         // MOV Rn,A (F8-FF) / MOV @Ri,A (F6-F7)
         cls = CLS_RAM;
         wr  = 1'b1;
         ram = opcode_i[3] ? WR_RAM_REG : WR_RAM_REG_IND;
      end
   end

   assign decode_o = '{
      op_class: cls,
      two_byte: (cls == CLS_TWO_BYTE),
      illegal:  (cls == CLS_ILLEGAL),
      info:     '{ram_code: ram, alu_code: alu, is_jump: jmp, is_write: wr}
   };

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
// Instruction-sequencing FSM for the 8051 core. Each clock edge that is not
// held executes one FSM step; the strobes that step issues are registered and
// visible to the datapath for the following cycle.
//
// Parameters:
//   RAM_WAIT        extra cycles RAM_access is held in MEM (0..7)
//   ILLEGAL_AS_NOP  1: unsupported opcode retires as NOP, 0: park in HALT
//
// Ports:
//   clock       in   1  core clock, rising edge
//   reset       in   1  asynchronous active-low reset
//   Opcode      in   8  current IR from the datapath
//   hold        in   1  stall request, freezes the FSM
//   IRload      out  1  fetch strobe
//   PCload      out  1  PC increment strobe
//   NotRload    out  1  second-byte fetch (operand into addr1)
//   RAM_access  out  4  RAM access code
//   Aload       out  1  ALU execute / accumulator writeback
//   ALU_Opcode  out  4  ALU operation code
//   JMPload     out  1  jump strobe
//   instr_done  out  1  pulse on the last cycle of each instruction
//   illegal     out  1  pulse on the DECODE cycle of an unsupported opcode
// -----------------------------------------------------------------------------
module control_unit
   import control_unit_pkg::*;
#(
   parameter int unsigned RAM_WAIT       = 0,
   parameter bit          ILLEGAL_AS_NOP = 1'b1
)
(
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] Opcode,
   input  logic       hold,
   output logic       IRload,
   output logic       PCload,
   output logic       NotRload,
   output logic [3:0] RAM_access,
   output logic       Aload,
   output logic [3:0] ALU_Opcode,
   output logic       JMPload,
   output logic       instr_done,
   output logic       illegal
);

   localparam logic [2:0] WAIT_LAST = 3'(RAM_WAIT);

   logic [2:0] state_q, state_d;
   logic [2:0] cnt_q,   cnt_d;
   exec_info_t info_q,  info_d;
   ctrl_t      ctrl_q,  ctrl_d;
   decode_t    dec_w;

   control_unit_opcode_classifier u_opcode_classifier (
      .opcode_i (Opcode),
      .decode_o (dec_w)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      info_d  = info_q;
      ctrl_d  = CTRL_IDLE;

      // While held nothing advances and every strobe reads idle.
      if (!hold) begin
         case (state_q)
            S_FETCH1: begin
               ctrl_d.ir_load = 1'b1;
               ctrl_d.pc_load = 1'b1;
               state_d        = S_DECODE;
            end

            S_DECODE: begin
               info_d = dec_w.info;
               cnt_d  = '0;
               if (dec_w.illegal) begin
                  ctrl_d.illegal = 1'b1;
                  if (ILLEGAL_AS_NOP) begin
                     ctrl_d.instr_done = 1'b1;
                     state_d           = S_FETCH1;
                  end else begin
                     state_d = S_HALT;
                  end
               end else if (dec_w.op_class == CLS_NOP) begin
                  ctrl_d.instr_done = 1'b1;
                  state_d           = S_FETCH1;
               end else if (dec_w.two_byte) begin
                  state_d = S_FETCH2;
               end else if (dec_w.op_class == CLS_ACC) begin
                  state_d = S_EXEC;
               end else begin
                  state_d = S_MEM;
               end
            end

            S_FETCH2: begin
               ctrl_d.ir_load   = 1'b1;
               ctrl_d.pc_load   = 1'b1;
               ctrl_d.notr_load = 1'b1;
               state_d          = info_q.is_jump ? S_JUMP : S_MEM;
            end

            S_MEM: begin
               ctrl_d.ram_access = info_q.ram_code;
               if (cnt_q == WAIT_LAST) begin
                  cnt_d = '0;
                  if (info_q.is_write) begin
                     ctrl_d.instr_done = 1'b1;
                     state_d           = S_FETCH1;
                  end else begin
                     state_d = S_EXEC;
                  end
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end

            S_EXEC: begin
               ctrl_d.a_load     = 1'b1;
               ctrl_d.alu_opcode = info_q.alu_code;
               ctrl_d.instr_done = 1'b1;
               state_d           = S_FETCH1;
            end

            S_JUMP: begin
               ctrl_d.jmp_load   = 1'b1;
               ctrl_d.instr_done = 1'b1;
               state_d           = S_FETCH1;
            end

            S_HALT: begin
               state_d = S_HALT;
            end

            default: begin
               state_d = S_FETCH1;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH1;
         cnt_q   <= '0;
         info_q  <= INFO_NONE;
         ctrl_q  <= CTRL_IDLE;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         info_q  <= info_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign IRload     = ctrl_q.ir_load;
   assign PCload     = ctrl_q.pc_load;
   assign NotRload   = ctrl_q.notr_load;
   assign RAM_access = ctrl_q.ram_access;
   assign Aload      = ctrl_q.a_load;
   assign ALU_Opcode = ctrl_q.alu_opcode;
   assign JMPload    = ctrl_q.jmp_load;
   assign instr_done = ctrl_q.instr_done;
   assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
// Directed bench for control_unit. Two instances share every input:
//   dut_a: RAM_WAIT=0, ILLEGAL_AS_NOP=1
//   dut_b: RAM_WAIT=2, ILLEGAL_AS_NOP=0
// Each instance's outputs are packed into one 15-bit word
//   {IRload, PCload, NotRload, RAM_access, Aload, ALU_Opcode, JMPload,
//    instr_done, illegal}
// and compared against hand-written expected words at each falling edge.
// -----------------------------------------------------------------------------
module tb_control_unit;
   import control_unit_pkg::*;

   logic       clock  = 1'b0;
   logic       reset  = 1'b1;
   logic [7:0] Opcode = 8'h00;
   logic       hold   = 1'b0;

   logic       irload_a, pcload_a, notrload_a, aload_a, jmpload_a, done_a, ill_a;
   logic [3:0] ram_a, alu_a;
   logic       irload_b, pcload_b, notrload_b, aload_b, jmpload_b, done_b, ill_b;
   logic [3:0] ram_b, alu_b;
   logic [14:0] obs_a, obs_b;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   control_unit #(.RAM_WAIT(0), .ILLEGAL_AS_NOP(1'b1)) dut_a (
      .clock (clock), .reset (reset), .Opcode (Opcode), .hold (hold),
      .IRload (irload_a), .PCload (pcload_a), .NotRload (notrload_a),
      .RAM_access (ram_a), .Aload (aload_a), .ALU_Opcode (alu_a),
      .JMPload (jmpload_a), .instr_done (done_a), .illegal (ill_a)
   );

   control_unit #(.RAM_WAIT(2), .ILLEGAL_AS_NOP(1'b0)) dut_b (
      .clock (clock), .reset (reset), .Opcode (Opcode), .hold (hold),
      .IRload (irload_b), .PCload (pcload_b), .NotRload (notrload_b),
      .RAM_access (ram_b), .Aload (aload_b), .ALU_Opcode (alu_b),
      .JMPload (jmpload_b), .instr_done (done_b), .illegal (ill_b)
   );

   assign obs_a = {irload_a, pcload_a, notrload_a, ram_a, aload_a, alu_a,
                   jmpload_a, done_a, ill_a};
   assign obs_b = {irload_b, pcload_b, notrload_b, ram_b, aload_b, alu_b,
                   jmpload_b, done_b, ill_b};

   function automatic logic [14:0] ex(input logic ir, input logic pc,
                                      input logic nr, input logic [3:0] ram,
                                      input logic a, input logic [3:0] alu,
                                      input logic jmp, input logic done,
                                      input logic ill);
      return {ir, pc, nr, ram, a, alu, jmp, done, ill};
   endfunction

   function automatic logic [14:0] mem_v(input logic [3:0] ram, input logic done);
      return ex(1'b0, 1'b0, 1'b0, ram, 1'b0, ALU_NOP, 1'b0, done, 1'b0);
   endfunction

   function automatic logic [14:0] exec_v(input logic [3:0] alu);
      return ex(1'b0, 1'b0, 1'b0, RAM_IDLE, 1'b1, alu, 1'b0, 1'b1, 1'b0);
   endfunction

   task automatic check(input string tag, input logic [14:0] obs,
                        input logic [14:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Leaves reset released on a falling edge; the next cycle shows FETCH1.
   task automatic do_reset();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   logic [14:0] e_idle, e_f1, e_f2, e_done, e_jmp, e_ill_nop, e_ill_halt;
   logic [14:0] seq_a [8];
   logic [14:0] seq_b [8];

   initial begin
      e_idle     = ex(1'b0, 1'b0, 1'b0, RAM_IDLE, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0);
      e_f1       = ex(1'b1, 1'b1, 1'b0, RAM_IDLE, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0);
      e_f2       = ex(1'b1, 1'b1, 1'b1, RAM_IDLE, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b0);
      e_done     = ex(1'b0, 1'b0, 1'b0, RAM_IDLE, 1'b0, ALU_NOP, 1'b0, 1'b1, 1'b0);
      e_jmp      = ex(1'b0, 1'b0, 1'b0, RAM_IDLE, 1'b0, ALU_NOP, 1'b1, 1'b1, 1'b0);
      e_ill_nop  = ex(1'b0, 1'b0, 1'b0, RAM_IDLE, 1'b0, ALU_NOP, 1'b0, 1'b1, 1'b1);
      e_ill_halt = ex(1'b0, 1'b0, 1'b0, RAM_IDLE, 1'b0, ALU_NOP, 1'b0, 1'b0, 1'b1);

      // Reset state
      #2 reset = 1'b0;
      Opcode = 8'h28;
      cyc();
      cyc();
      check("reset_a", obs_a, e_idle);
      check("reset_b", obs_b, e_idle);
      reset = 1'b1;

      // ADD A,R0: FETCH1, DECODE, MEM(RD_RAM_REG), EXEC(ADD)
      cyc(); check("add_fetch1", obs_a, e_f1);
      cyc(); check("add_decode", obs_a, e_idle);
      cyc(); check("add_mem", obs_a, mem_v(RD_RAM_REG, 1'b0));
      cyc(); check("add_exec", obs_a, exec_v(ALU_ADD));
      cyc(); check("add2_fetch1", obs_a, e_f1);
      cyc(); check("add2_decode", obs_a, e_idle);
      cyc(); check("add2_mem", obs_a, mem_v(RD_RAM_REG, 1'b0));

      // Reset mid-MEM for 3 cycles, then release
      reset = 1'b0;
      #1 check("reset_async", obs_a, e_idle);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check($sformatf("reset_low_%0d", i), obs_a, e_idle);
      end
      reset = 1'b1;
      cyc(); check("reset_release_fetch", obs_a, e_f1);

      // MOV A,#imm on both widths of RAM wait
      Opcode = 8'h74;
      do_reset();
      seq_a = '{e_f1, e_idle, e_f2, mem_v(RD_RAM_IM, 1'b0), exec_v(ALU_NOP),
                e_f1, e_idle, e_idle};
      seq_b = '{e_f1, e_idle, e_f2, mem_v(RD_RAM_IM, 1'b0),
                mem_v(RD_RAM_IM, 1'b0), mem_v(RD_RAM_IM, 1'b0), exec_v(ALU_NOP),
                e_idle};
      for (int i = 0; i < 7; i++) begin
         cyc();
         check($sformatf("movimm_a_c%0d", i + 1), obs_a, seq_a[i]);
         check($sformatf("movimm_b_c%0d", i + 1), obs_b, seq_b[i]);
      end

      // JZ then AJMP: FETCH2 then a single JMPload, no RAM access
      Opcode = 8'h60;
      do_reset();
      seq_a = '{e_f1, e_idle, e_f2, e_jmp, e_idle, e_idle, e_idle, e_idle};
      for (int i = 0; i < 4; i++) begin
         cyc();
         check($sformatf("jz_a_c%0d", i + 1), obs_a, seq_a[i]);
         check($sformatf("jz_b_c%0d", i + 1), obs_b, seq_a[i]);
      end
      Opcode = 8'h21;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check($sformatf("ajmp_a_c%0d", i + 1), obs_a, seq_a[i]);
         check($sformatf("ajmp_b_c%0d", i + 1), obs_b, seq_a[i]);
      end

      // MOV R1,A with hold for two cycles
      Opcode = 8'hF9;
      do_reset();
      seq_a = '{e_f1, e_idle, mem_v(WR_RAM_REG, 1'b1), e_f1, e_idle, e_idle,
                e_idle, mem_v(WR_RAM_REG, 1'b1)};
      seq_b = '{e_f1, e_idle, mem_v(WR_RAM_REG, 1'b0), mem_v(WR_RAM_REG, 1'b0),
                e_idle, e_idle, mem_v(WR_RAM_REG, 1'b1), e_f1};
      for (int i = 0; i < 8; i++) begin
         cyc();
         check($sformatf("hold_a_c%0d", i + 1), obs_a, seq_a[i]);
         check($sformatf("hold_b_c%0d", i + 1), obs_b, seq_b[i]);
         if (i == 3) hold = 1'b1;
         if (i == 5) hold = 1'b0;
      end

      // DEC A, NOP, SUBB A,@R0, ORL A,#imm back to back
      Opcode = 8'h14;
      do_reset();
      cyc(); check("dec_fetch1", obs_a, e_f1);
      cyc(); check("dec_decode", obs_a, e_idle);
      cyc(); check("dec_exec", obs_a, exec_v(ALU_DEC));
      Opcode = 8'h00;
      cyc(); check("nop_fetch1", obs_a, e_f1);
      cyc(); check("nop_decode_done", obs_a, e_done);
      Opcode = 8'h96;
      cyc(); check("subb_fetch1", obs_a, e_f1);
      cyc(); check("subb_decode", obs_a, e_idle);
      cyc(); check("subb_mem", obs_a, mem_v(RD_RAM_REG_IND, 1'b0));
      cyc(); check("subb_exec", obs_a, exec_v(ALU_SUBB));
      Opcode = 8'h44;
      cyc(); check("orl_fetch1", obs_a, e_f1);
      cyc(); check("orl_decode", obs_a, e_idle);
      cyc(); check("orl_fetch2", obs_a, e_f2);
      cyc(); check("orl_mem", obs_a, mem_v(RD_RAM_IM, 1'b0));
      cyc(); check("orl_exec", obs_a, exec_v(ALU_ORL));

      // Unsupported opcode: NOP on dut_a, HALT on dut_b
      Opcode = 8'hA5;
      do_reset();
      cyc();
      check("ill_a_fetch1", obs_a, e_f1);
      check("ill_b_fetch1", obs_b, e_f1);
      cyc();
      check("ill_a_decode", obs_a, e_ill_nop);
      check("ill_b_decode", obs_b, e_ill_halt);
      cyc();
      check("ill_a_next_fetch", obs_a, e_f1);
      check("halt_b_0", obs_b, e_idle);
      for (int i = 1; i < 20; i++) begin
         cyc();
         check($sformatf("halt_b_%0d", i), obs_b, e_idle);
      end

      // Reset exits HALT; hold still asserted at release keeps FETCH1 frozen
      hold = 1'b1;
      do_reset();
      cyc(); check("held_after_reset_b", obs_b, e_idle);
      hold = 1'b0;
      cyc(); check("halt_exit_fetch1_b", obs_b, e_f1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
